// File: rtl/frame_draw_sequencer_if.sv
// Draw request channel between the frame sequencer and the tile-draw engine.
// Request fields stay stable from req rise until ack is sampled.
interface frame_draw_sequencer_if;
  logic       draw_req;
  logic [3:0] draw_x;
  logic [3:0] draw_y;
  logic [2:0] draw_code;
  logic       draw_ack;

  modport master (
    output draw_req, draw_x, draw_y, draw_code,
    input  draw_ack
  );

  modport slave (
    input  draw_req, draw_x, draw_y, draw_code,
    output draw_ack
  );
endinterface

// File: rtl/frame_draw_sequencer.sv
// Raster pass sequencer: scans the frame tracker once per tick and
// hands each changed cell to the tile-draw engine.
module frame_draw_sequencer #(
  parameter int GRID_CELLS = 192,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       frame_tick,
  input  logic       trk_diff,
  input  logic [2:0] trk_obj_code,
  input  logic [3:0] trk_x,
  input  logic [3:0] trk_y,
  output logic       track_en,
  frame_draw_sequencer_if.master dif,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] changed_count,
  output logic       overrun,
  output logic       timeout_err,
  input  logic       clear_err
);

  typedef enum logic [1:0] {
    IDLE, SCAN, DRAW, FINISH
  } state_e;

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  localparam logic [7:0] CLAST = 8'(GRID_CELLS - 1);

  state_e state_q, state_d;

  logic [7:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    run_q, run_d;
  logic [7:0]    cc_q, cc_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          terr_q, terr_d;
  logic          req_q, req_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic [2:0]    code_q, code_d;
  logic          tmo;

  assign tmo = (TIMEOUT != 0) && (wait_q == WLAST)
               && !dif.draw_ack;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (frame_tick) state_d = SCAN;
      SCAN: begin
        if (trk_diff)            state_d = DRAW;
        else if (cnt_q == CLAST) state_d = FINISH;
      end
      DRAW:   if (dif.draw_ack || tmo) state_d = SCAN;
      FINISH: state_d = (pend_q || frame_tick) ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    track_en   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      SCAN: begin
        busy     = 1'b1;
        track_en = !trk_diff;
      end
      DRAW:    busy = 1'b1;
      FINISH:  frame_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    wait_d = wait_q;
    run_d  = run_q;
    cc_d   = cc_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    terr_d = terr_q;
    req_d  = req_q;
    x_d    = x_q;
    y_d    = y_q;
    code_d = code_q;
    if (clear_err) begin
      ovr_d  = 1'b0;
      terr_d = 1'b0;
    end
    unique case (state_q)
      SCAN: begin
        if (trk_diff) begin
          x_d    = trk_x;
          y_d    = trk_y;
          code_d = trk_obj_code;
          req_d  = 1'b1;
          wait_d = '0;
          if (run_q != 8'hFF) run_d = run_q + 8'd1;
        end else begin
          cnt_d = (cnt_q == CLAST) ? 8'd0 : cnt_q + 8'd1;
        end
      end
      DRAW: begin
        if (dif.draw_ack) begin
          req_d  = 1'b0;
          wait_d = '0;
        end else if (tmo) begin
          req_d  = 1'b0;
          wait_d = '0;
          terr_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FINISH: begin
        cc_d  = run_q;
        run_d = 8'd0;
        if (pend_q || frame_tick) pend_d = 1'b0;
      end
      default: ;
    endcase
    // a second tick while one is queued is dropped and flagged
    if (frame_tick && busy) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      wait_q <= '0;
      run_q  <= '0;
      cc_q   <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      terr_q <= 1'b0;
      req_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      code_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      run_q  <= run_d;
      cc_q   <= cc_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      terr_q <= terr_d;
      req_q  <= req_d;
      x_q    <= x_d;
      y_q    <= y_d;
      code_q <= code_d;
    end
  end

  assign dif.draw_req  = req_q;
  assign dif.draw_x    = x_q;
  assign dif.draw_y    = y_q;
  assign dif.draw_code = code_q;
  assign changed_count = cc_q;
  assign overrun       = ovr_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed bench for frame_draw_sequencer with a behavioural
// tracker and a delay-programmable draw engine.
module tb_frame_draw_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       clear_err = 1'b0;
  logic       trk_diff;
  logic [2:0] trk_obj_code;
  logic [3:0] trk_x;
  logic [3:0] trk_y;
  logic       track_en;
  logic       busy;
  logic       frame_done;
  logic [7:0] changed_count;
  logic       overrun;
  logic       timeout_err;

  always #5 clk = ~clk;

  frame_draw_sequencer_if dif ();

  frame_draw_sequencer #(
    .GRID_CELLS(192),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .frame_tick(frame_tick),
    .trk_diff(trk_diff),
    .trk_obj_code(trk_obj_code),
    .trk_x(trk_x),
    .trk_y(trk_y),
    .track_en(track_en),
    .dif(dif.master),
    .busy(busy),
    .frame_done(frame_done),
    .changed_count(changed_count),
    .overrun(overrun),
    .timeout_err(timeout_err),
    .clear_err(clear_err)
  );

  // tracker: one marked cell differs until it has been handed out
  logic [7:0] tcell;
  int         mark_cell = -1;
  logic [2:0] mark_code = 3'd0;
  int         mark_gen = 0;
  int         served_gen;

  assign trk_x = tcell[3:0];
  assign trk_y = tcell[7:4];
  assign trk_diff = (int'(tcell) == mark_cell)
                    && (served_gen != mark_gen);
  assign trk_obj_code = (int'(tcell) == mark_cell)
                        ? mark_code : 3'd0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tcell <= 8'd0;
    end else begin
      if (track_en)
        tcell <= (tcell == 8'd191) ? 8'd0 : tcell + 8'd1;
      if (dif.draw_req) served_gen <= mark_gen;
    end
  end

  // draw engine: ack in the ack_delay-th request cycle, 0 = never
  int         ack_delay = 0;
  int         req_cyc = 0;
  int         hold = 0;
  int         unstable = 0;
  logic [3:0] cx, cy;
  logic [2:0] cc;

  always @(negedge clk) begin
    if (dif.draw_req) begin
      req_cyc = req_cyc + 1;
      if (req_cyc == 1) begin
        cx = dif.draw_x;
        cy = dif.draw_y;
        cc = dif.draw_code;
      end else if (cx !== dif.draw_x || cy !== dif.draw_y
                   || cc !== dif.draw_code) begin
        unstable = unstable + 1;
      end
      hold = req_cyc;
      dif.draw_ack = (ack_delay != 0) && (req_cyc == ack_delay);
    end else begin
      req_cyc = 0;
      dif.draw_ack = 1'b0;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_pass();
    @(negedge clk);
    frame_tick = 1'b1;
  endtask

  // cycle 1 is the first SCAN cycle after the starting tick
  task automatic run_pass(input bit tick_draw,
                          input int tick_cyc,
                          output int ens,
                          output int done,
                          output int stall);
    int cyc;
    bit injected;
    cyc = 0;
    ens = 0;
    done = 0;
    stall = 0;
    injected = 1'b0;
    while (cyc < 1000 && done == 0) begin
      @(negedge clk);
      cyc++;
      frame_tick = 1'b0;
      if (track_en) ens++;
      else if (busy && !dif.draw_req && stall == 0) stall = cyc;
      if (tick_draw && dif.draw_req && !injected) begin
        frame_tick = 1'b1;
        injected = 1'b1;
      end
      if (cyc == tick_cyc) frame_tick = 1'b1;
      if (frame_done) done = cyc;
    end
    frame_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  int ens, done, stall;
  bit seen;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req", dif.draw_req, 0);
    check("rst_en", track_en, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", changed_count, 0);
    check("rst_ovr", overrun, 0);
    check("rst_tmo", timeout_err, 0);
    nrst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // clean pass
    start_pass();
    run_pass(0, 0, ens, done, stall);
    check("t1_en", ens, 192);
    check("t1_done", done, 193);
    @(negedge clk);
    check("t1_pulse", frame_done, 0);
    check("t1_idle", busy, 0);
    check("t1_cnt", changed_count, 0);

    // one change at (3,2), ack after 5 cycles
    mark_cell = 35;
    mark_code = 3'd3;
    mark_gen++;
    ack_delay = 5;
    start_pass();
    run_pass(0, 0, ens, done, stall);
    check("t2_en", ens, 192);
    check("t2_stall", stall, 36);
    check("t2_done", done, 199);
    check("t2_hold", hold, 5);
    check("t2_x", cx, 3);
    check("t2_y", cy, 2);
    check("t2_code", cc, 3);
    @(negedge clk);
    check("t2_cnt", changed_count, 1);

    // last cell, immediate ack
    mark_cell = 191;
    mark_code = 3'd4;
    mark_gen++;
    ack_delay = 1;
    start_pass();
    run_pass(0, 0, ens, done, stall);
    check("t3_en", ens, 192);
    check("t3_stall", stall, 192);
    check("t3_done", done, 195);
    check("t3_hold", hold, 1);
    check("t3_x", cx, 15);
    check("t3_y", cy, 11);
    check("t3_code", cc, 4);
    @(negedge clk);
    check("t3_cnt", changed_count, 1);
    check("t3_idle", busy, 0);

    // tick during draw, second tick overruns
    mark_cell = 10;
    mark_code = 3'd2;
    mark_gen++;
    ack_delay = 4;
    start_pass();
    run_pass(1, 100, ens, done, stall);
    check("t4_done1", done, 198);
    check("t4_ovr", overrun, 1);
    run_pass(0, 0, ens, done, stall);
    check("t4_en2", ens, 192);
    check("t4_done2", done, 193);
    @(negedge clk);
    check("t4_cnt2", changed_count, 0);
    check("t4_idle", busy, 0);
    pulse_clear();
    check("t4_clr", overrun, 0);

    // no ack: draw times out after 8 cycles
    mark_cell = 50;
    mark_code = 3'd1;
    mark_gen++;
    ack_delay = 0;
    start_pass();
    run_pass(0, 0, ens, done, stall);
    check("t5_en", ens, 192);
    check("t5_stall", stall, 51);
    check("t5_done", done, 202);
    check("t5_hold", hold, 8);
    check("t5_tmo", timeout_err, 1);
    @(negedge clk);
    check("t5_cnt", changed_count, 1);
    pulse_clear();
    check("t5_clr", timeout_err, 0);

    // reset in the middle of a draw
    mark_cell = 5;
    mark_code = 3'd2;
    mark_gen++;
    ack_delay = 0;
    start_pass();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (dif.draw_req) seen = 1'b1;
    end
    check("t6_req_seen", seen, 1);
    nrst = 1'b0;
    mark_cell = -1;
    #1;
    check("t6_req", dif.draw_req, 0);
    check("t6_busy", busy, 0);
    check("t6_en", track_en, 0);
    @(negedge clk);
    nrst = 1'b1;
    start_pass();
    run_pass(0, 0, ens, done, stall);
    check("t6_en2", ens, 192);
    check("t6_done", done, 193);
    @(negedge clk);
    check("t6_cnt", changed_count, 0);
    check("stable", unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_draw_sequencer.md
Name: frame_draw_sequencer

Overview:
Controls the 16x12 frame tracker. On each game-update tick it runs one full raster pass over the grid. It stalls the tracker whenever the tracker flags a changed cell, and hands that cell (x, y, object code) to the downstream tile-draw engine over a req/ack handshake. It reports pass completion, per-pass change count, and error flags to the top-level game controller.

Parameters:
GRID_CELLS, 192, cells per pass (16 x 12); counter width is 8 bits.
TIMEOUT, 1023, max cycles draw_req may wait for draw_ack; 0 disables the timeout.

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
frame_tick  in  1  one-cycle pulse requesting a new pass
trk_diff  in  1  tracker diff flag for the current cell
trk_obj_code  in  3  tracker object code (0 blank, 1 head, 2 body, 3 apple, 4 border)
trk_x  in  4  tracker current column, 0..15
trk_y  in  4  tracker current row, 0..11
track_en  out  1  tracker advance enable
draw_req  out  1  draw request to the tile engine
draw_x  out  4  column of the cell to draw
draw_y  out  4  row of the cell to draw
draw_code  out  3  object code of the cell to draw
draw_ack  in  1  draw engine accepts/completes the request
busy  out  1  pass in progress
frame_done  out  1  one-cycle pulse at the end of a pass
changed_count  out  8  number of draws issued in the last completed pass
overrun  out  1  sticky: tick arrived while one was already pending
timeout_err  out  1  sticky: a draw request timed out
clear_err  in  1  clears overrun and timeout_err

Behaviour:
- Reset: state IDLE. All outputs 0. Cell counter, wait counter, pending flag and running change count are 0.
- States: IDLE, SCAN, DRAW, FINISH. busy = (state is SCAN or DRAW).
- track_en is combinational: 1 only when state==SCAN and trk_diff==0. A diff therefore stalls the tracker on the changed cell in the same cycle.
- IDLE: frame_tick=1 -> SCAN next cycle.
- SCAN, trk_diff=0:
  - The tracker advances and the cell counter increments.
  - If the counter was GRID_CELLS-1, the counter returns to 0 and the state goes to FINISH.
- SCAN, trk_diff=1:
  - Register draw_x=trk_x, draw_y=trk_y, draw_code=trk_obj_code.
  - Set draw_req=1 and increment the running change count (saturating at 255).
  - Go to DRAW. The cell counter holds.
  - While the tracker is stalled, its stored cell is updated, so its diff drops. On return to SCAN the cell is re-evaluated; if it changed again it is redrawn.
- DRAW:
  - draw_req and draw_x/y/code stay stable until draw_ack is sampled high.
  - On ack: draw_req=0 next cycle, wait counter cleared, state back to SCAN.
  - draw_ack while draw_req=0 is ignored.
- Timeout (TIMEOUT!=0): if the wait counter reaches TIMEOUT-1 with no ack, drop draw_req, set timeout_err and return to SCAN. That cell is not redrawn.
- FINISH (one cycle):
  - frame_done=1; changed_count is loaded from the running count, which is then cleared.
  - If pending or frame_tick is set -> SCAN and clear pending; otherwise -> IDLE.
- frame_tick in SCAN or DRAW: sets pending. If pending is already set, set overrun instead; the extra tick is dropped.
- clear_err=1 clears both sticky flags. A set event in the same cycle wins over the clear.
- Alignment: the tracker and this block share reset, and advance counts are always multiples of GRID_CELLS. The cell counter therefore equals trk_y*16+trk_x at the start of every pass.
- Asynchronous reset mid-pass returns to IDLE immediately: draw_req=0 and all flags cleared.

Test Plan:
1. Reset, then tick with trk_diff held 0 -> busy=1 from cycle 1; track_en=1 for exactly 192 cycles; frame_done pulses at cycle 193; changed_count=0; back to IDLE.
2. trk_diff=1 at cell (3,2) with code 3; ack 5 cycles after req -> track_en=0 in the diff cycle; draw_req=1 with draw_x=3, draw_y=2, draw_code=3 held for 5 cycles; req drops the cycle after ack; scan resumes; changed_count=1 at frame_done.
3. Diff at cell (15,11), the last cell, ack immediately -> the draw completes before frame_done; the pass ends; the next pass starts at counter 0.
4. Tick during DRAW, then a second tick -> first tick: pending=1, FINISH goes directly to SCAN, no IDLE cycle. Second tick: overrun=1. clear_err -> overrun=0.
5. TIMEOUT=8, draw_ack never asserted -> draw_req drops after 8 cycles, timeout_err=1, the scan continues and frame_done still pulses.
6. Assert nrst low during DRAW -> draw_req, busy and track_en are 0 immediately; after release, a tick starts a clean 192-cell pass.
